// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
//   Registered 1-bit full adder. It computes {cout,sum} = s0 + s1 + carry-in
//   and is used as the leaf arithmetic cell of ripple-carry and bit-serial
//   datapaths.
//
// Parameters
//   REG_OUT  1: sum/cout/out_valid are registered, with a latency of 1 clk.
//            0: sum/cout/out_valid are combinational, with zero latency.
//   RST_SUM  Value that sum takes during reset (0 or 1).
//
// Optional build macro
//   FULL_ADDER_SERIAL_CARRY_EN
//     Adds the 'serial' and 'first' inputs and an internal carry register.
//     This supports LSB-first bit-serial addition. The macro is undefined by
//     default, and then cin is always used as the carry-in.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   s0, s1     in   operand bits A and B
//   cin        in   carry-in
//   in_valid   in   operands are valid this cycle
//   serial     in   (macro only) use the internal carry register instead of cin
//   first      in   (macro only) force the carry-in to cin for this bit (LSB)
//   sum        out  s0 ^ s1 ^ carry-in
//   cout       out  majority(s0, s1, carry-in)
//   out_valid  out  sum/cout hold a fresh result
// -----------------------------------------------------------------------------
module full_adder_1bit #(
  parameter int REG_OUT = 1,
  parameter int RST_SUM = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s0,
  input  logic s1,
  input  logic cin,
  input  logic in_valid,
`ifdef FULL_ADDER_SERIAL_CARRY_EN
  input  logic serial,
  input  logic first,
`endif
  output logic sum,
  output logic cout,
  output logic out_valid
);

  localparam logic RST_SUM_BIT = 1'(RST_SUM);

  logic carry_used;
  logic sum_next;
  logic cout_next;

`ifdef FULL_ADDER_SERIAL_CARRY_EN
  // The carry register links consecutive bits of a serial word. On the LSB
  // ('first'), the register is bypassed so that a stale carry from the
  // previous word is not folded in.
  logic carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
    end else if (in_valid) begin
      carry_reg <= cout_next;
    end
  end

  always_comb begin
    carry_used = cin;
    if (serial && !first) begin
      carry_used = carry_reg;
    end
  end
`else
  always_comb begin
    carry_used = cin;
  end
`endif

  // Full-adder equations.
  always_comb begin
    sum_next  = s0 ^ s1 ^ carry_used;
    cout_next = (s0 & s1) | (s0 & carry_used) | (s1 & carry_used);
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic sum_reg;
      logic cout_reg;
      logic valid_reg;

      // The result registers load only on in_valid. This means X values on
      // idle inputs never reach the held sum/cout.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_reg   <= RST_SUM_BIT;
          cout_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= in_valid;
          if (in_valid) begin
            sum_reg  <= sum_next;
            cout_reg <= cout_next;
          end
        end
      end

      assign sum       = sum_reg;
      assign cout      = cout_reg;
      assign out_valid = valid_reg;
    end else begin : g_comb_out
      assign sum       = sum_next;
      assign cout      = cout_next;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_1bit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_1bit
//   Directed, self-checking bench for full_adder_1bit in its default build
//   (REG_OUT=1, RST_SUM=0, serial carry macro undefined).
//
//   Each step drives one set of operands and pushes the expected output to a
//   queue. One clock later, the step pops that entry and compares it with the
//   DUT outputs. The expected sum/cout come from a 2-bit arithmetic add.
// -----------------------------------------------------------------------------
module tb_full_adder_1bit;

  localparam int RST_SUM = 0;

  logic clk;
  logic rst_n;
  logic s0;
  logic s1;
  logic cin;
  logic in_valid;
  logic sum;
  logic cout;
  logic out_valid;

  typedef struct packed {
    logic sum;
    logic cout;
    logic valid;
  } exp_t;

  exp_t exp_q[$];
  logic last_sum;
  logic last_cout;
  int   checks;
  int   errors;

  full_adder_1bit #(
    .REG_OUT(1),
    .RST_SUM(RST_SUM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0       (s0),
    .s1       (s1),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check the result one clock later.
  task automatic step(input logic a, input logic b, input logic c, input logic v);
    exp_t       e;
    logic [1:0] t;
    s0       = a;
    s1       = b;
    cin      = c;
    in_valid = v;
    if (v === 1'b1) begin
      t         = {1'b0, a} + {1'b0, b} + {1'b0, c};
      last_sum  = t[0];
      last_cout = t[1];
    end
    e.sum   = last_sum;
    e.cout  = last_cout;
    e.valid = (v === 1'b1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sum", sum, e.sum);
    chk("cout", cout, e.cout);
    chk("out_valid", out_valid, e.valid);
    $display("step s0=%b s1=%b cin=%b v=%b -> sum=%b cout=%b ov=%b (exp %b %b %b)",
             a, b, c, v, sum, cout, out_valid, e.sum, e.cout, e.valid);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    s0        = 1'b0;
    s1        = 1'b0;
    cin       = 1'b0;
    in_valid  = 1'b0;
    last_sum  = 1'(RST_SUM);
    last_cout = 1'b0;

    // Reset state.
    #2;
    chk("rst_sum", sum, 1'(RST_SUM));
    chk("rst_cout", cout, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back exhaustive sweep, then idle (outputs hold).
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = 3'(i);
      step(v3[2], v3[1], v3[0], 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Idle X inputs must not disturb the held outputs.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'bx, 1'bx, 1'bx, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // Async reset between edges, with a result pending.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    s0       = 1'b1;
    s1       = 1'b1;
    cin      = 1'b1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum", sum, 1'(RST_SUM));
    chk("async_rst_cout", cout, 1'b0);
    chk("async_rst_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("held_rst_sum", sum, 1'(RST_SUM));
    chk("held_rst_valid", out_valid, 1'b0);
    rst_n     = 1'b1;
    last_sum  = 1'(RST_SUM);
    last_cout = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
